// File: rtl/vending_pkg.sv
// Encodings shared by the coin front end and the vending FSM so both sides
// decode the coin bus identically.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIVE     = 3'd1,
        ST_TEN      = 3'd2,
        ST_FIFTEEN  = 3'd3,
        ST_DISPENSE = 3'd4
    } vend_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs, candy hold and the coin bus between the acceptor and its user.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4
);
    import vending_pkg::*;

    logic                        sense_nickel;
    logic                        sense_dime;
    logic                        candy;
    coin_t                       coin;
    logic                        coin_reject;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    modport master (
        output sense_nickel, sense_dime, candy,
        input  coin, coin_reject, fifo_count
    );

    modport slave (
        input  sense_nickel, sense_dime, candy,
        output coin, coin_reject, fifo_count
    );

endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchronizer plus counting debouncer; rise pulses for one cycle
// when the debounced level goes 0->1.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       s;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            rise  <= 1'b0;
            if (s != level) begin
                // the differing sample now seen is the Nth in a row
                if (cnt == CNT_LAST) begin
                    level <= s;
                    cnt   <= '0;
                    rise  <= s;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the nickel/dime sensors, resolves coin events and queues them in
// a small FIFO that is drained one coin per cycle unless candy holds it.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    coin_acceptor_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          rise_n;
    logic          rise_d;
    coin_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          reject_q;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          jam;
    logic          accept;
    logic          overflow;
    coin_t         push_code;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sense_nickel),
        .level (),
        .rise  (rise_n)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sense_dime),
        .level (),
        .rise  (rise_d)
    );

    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(FIFO_DEPTH));
        pop       = !empty && !bus.candy;
        jam       = rise_n && rise_d;
        push      = rise_n ^ rise_d;
        push_code = rise_d ? COIN_10 : COIN_5;
        // a pop in the same cycle frees the slot a full FIFO needs
        accept    = push && (!full || pop);
        overflow  = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wptr] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            reject_q <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            reject_q <= jam || overflow;
        end
    end

    assign bus.coin        = pop ? mem[rptr] : COIN_NONE;
    assign bus.coin_reject = reject_q;
    assign bus.fifo_count  = count;

endmodule
